// File: rtl/lvds_33_tx_serializer_if.sv
// Parallel-side handshake and serial line bundle for the LVDS transmit serializer.
// The master drives words and the training request. The slave (the serializer)
// returns the ready/busy status and the differential line pair.
interface lvds_33_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] D;
    logic                  D_VALID;
    logic                  D_READY;
    logic                  TRAIN;
    logic                  BUSY;
    logic                  O;
    logic                  OB;

    modport master (
        output D, D_VALID, TRAIN,
        input  D_READY, BUSY, O, OB
    );

    modport slave (
        input  D, D_VALID, TRAIN,
        output D_READY, BUSY, O, OB
    );
endinterface

// File: rtl/lvds_33_tx_serializer.sv
// LVDS transmit serializer: accepts parallel words over valid/ready and shifts
// them out one bit per clock on a complementary O/OB pair. Words can follow each
// other with no gap on the line. An alternating 1/0 training pattern is sent on
// request so the far-end receiver can align; the pattern always ends on a full
// 1,0 pair.
module lvds_33_tx_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    lvds_33_tx_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_TRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_o;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_shift;

    logic                  w_last;
    logic                  w_ready;
    logic                  w_accept;

    // Bit that goes on the line next, taken from the head of the word.
    function automatic logic f_head_bit(input logic [DATA_WIDTH-1:0] word);
        return MSB_FIRST ? word[DATA_WIDTH-1] : word[0];
    endfunction

    // Word with its head bit removed, so the next bit moves to the head.
    function automatic logic [DATA_WIDTH-1:0] f_advance(input logic [DATA_WIDTH-1:0] word);
        return MSB_FIRST ? (word << 1) : (word >> 1);
    endfunction

    // Ready during the last bit of a word, so the next word follows with no gap.
    // A pending TRAIN suppresses ready in IDLE, so training wins over data there.
    assign w_last   = (r_cnt == '0);
    assign w_ready  = !RST && (((r_state == S_IDLE) && !bus.TRAIN) ||
                               ((r_state == S_SHIFT) && w_last));
    assign w_accept = bus.D_VALID && w_ready;

    // OB comes from the same register as O, so the pair can never be equal.
    assign bus.D_READY = w_ready;
    assign bus.BUSY    = r_busy;
    assign bus.O       = r_o;
    assign bus.OB      = ~r_o;

    // Control FSM: state, bit counter, registered line level and busy flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_o     <= IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_SHIFT;
            r_cnt   <= CNT_W'(DATA_WIDTH - 1);
            r_o     <= f_head_bit(bus.D);
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.TRAIN) begin
                        r_state <= S_TRAIN;
                        r_o     <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_o     <= IDLE_LEVEL;
                        r_busy  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (!w_last) begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_o     <= f_head_bit(r_shift);
                    end else begin
                        r_state <= S_IDLE;
                        r_o     <= IDLE_LEVEL;
                        r_busy  <= 1'b0;
                    end
                end
                S_TRAIN: begin
                    // Leave only after a 0 has been sent, completing the 1,0 pair.
                    if (!r_o && !bus.TRAIN) begin
                        r_state <= S_IDLE;
                        r_o     <= IDLE_LEVEL;
                        r_busy  <= 1'b0;
                    end else begin
                        r_o     <= ~r_o;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_o     <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shift register: captures D on accept (minus the bit already sent) and
    // drops one bit per edge while shifting.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_shift <= f_advance(bus.D);
        end else if (r_state == S_SHIFT) begin
            r_shift <= f_advance(r_shift);
        end
    end
endmodule

// File: tb/tb_lvds_33_tx_serializer.sv
// Table-driven bench for the LVDS transmit serializer. Two instances share the
// stimulus: one MSB-first with idle level 0, one LSB-first with idle level 1.
// Each row selects which instance is checked.
module tb_lvds_33_tx_serializer;
    logic       clk;
    logic       tb_rst;
    logic       tb_dv;
    logic       tb_train;
    logic [7:0] tb_d;

    int n_checks;
    int n_errors;

    lvds_33_tx_serializer_if #(.DATA_WIDTH(8)) b0 ();
    lvds_33_tx_serializer_if #(.DATA_WIDTH(8)) b1 ();

    assign b0.D       = tb_d;
    assign b0.D_VALID = tb_dv;
    assign b0.TRAIN   = tb_train;
    assign b1.D       = tb_d;
    assign b1.D_VALID = tb_dv;
    assign b1.TRAIN   = tb_train;

    lvds_33_tx_serializer #(
        .DATA_WIDTH(8),
        .MSB_FIRST (1'b1),
        .IDLE_LEVEL(1'b0)
    ) u_msb (
        .CLK(clk),
        .RST(tb_rst),
        .bus(b0)
    );

    lvds_33_tx_serializer #(
        .DATA_WIDTH(8),
        .MSB_FIRST (1'b0),
        .IDLE_LEVEL(1'b1)
    ) u_lsb (
        .CLK(clk),
        .RST(tb_rst),
        .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       sel;   // 0 = MSB-first instance, 1 = LSB-first instance
        bit       rst;
        bit       dv;
        bit       train;
        bit [7:0] d;
        bit       rdy;   // D_READY expected just before the edge
        bit       o;     // O expected just after the edge
        bit       busy;  // BUSY expected just after the edge
    } vec_t;

    vec_t tbl[$];

    task automatic r(input bit sel, input bit rst, input bit dv, input bit train,
                     input bit [7:0] d, input bit rdy, input bit o, input bit busy);
        vec_t v;
        v.sel = sel; v.rst = rst; v.dv = dv; v.train = train;
        v.d = d; v.rdy = rdy; v.o = o; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %b, expected %b", name, row, act, exp);
        end
    endtask

    task automatic apply(input int row, input vec_t v);
        logic a_rdy, a_o, a_ob, a_busy;
        @(negedge clk);
        tb_rst   = v.rst;
        tb_dv    = v.dv;
        tb_train = v.train;
        tb_d     = v.d;
        #1;
        a_rdy = v.sel ? b1.D_READY : b0.D_READY;
        check("d_ready", row, a_rdy, v.rdy);
        @(posedge clk);
        #1;
        a_o    = v.sel ? b1.O    : b0.O;
        a_ob   = v.sel ? b1.OB   : b0.OB;
        a_busy = v.sel ? b1.BUSY : b0.BUSY;
        check("o",    row, a_o,    v.o);
        check("ob",   row, a_ob,   ~v.o);
        check("busy", row, a_busy, v.busy);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tb_rst   = 1'b1;
        tb_dv    = 1'b0;
        tb_train = 1'b0;
        tb_d     = 8'h00;

        // Reset with D_VALID and TRAIN high: nothing accepted, line idle.
        r(0,1,1,1,8'hA5, 0,0,0);
        r(0,1,1,1,8'hA5, 0,0,0);
        r(0,0,0,0,8'h00, 1,0,0);
        // Single word A5, MSB first: 1,0,1,0,0,1,0,1 then idle. D changes after accept.
        r(0,0,1,0,8'hA5, 1,1,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,0,0,0,8'h00, 1,0,0);
        r(0,0,0,0,8'h00, 1,0,0);
        // Back-to-back F0 then 0F with D_VALID held: 1111000000001111.
        r(0,0,1,0,8'hF0, 1,1,1);
        r(0,0,1,0,8'h0F, 0,1,1);
        r(0,0,1,0,8'h0F, 0,1,1);
        r(0,0,1,0,8'h0F, 0,1,1);
        r(0,0,1,0,8'h0F, 0,0,1);
        r(0,0,1,0,8'h0F, 0,0,1);
        r(0,0,1,0,8'h0F, 0,0,1);
        r(0,0,1,0,8'h0F, 0,0,1);
        r(0,0,1,0,8'h0F, 1,0,1);
        r(0,0,1,0,8'h0F, 0,0,1);
        r(0,0,1,0,8'h0F, 0,0,1);
        r(0,0,1,0,8'h0F, 0,0,1);
        r(0,0,1,0,8'h0F, 0,1,1);
        r(0,0,1,0,8'h0F, 0,1,1);
        r(0,0,1,0,8'h0F, 0,1,1);
        r(0,0,1,0,8'h0F, 0,1,1);
        r(0,0,0,0,8'h00, 1,0,0);
        // Training for 3 cycles with C3 pending: 1,0,1,0, idle, then C3 accepted.
        r(0,0,1,1,8'hC3, 0,1,1);
        r(0,0,1,1,8'hC3, 0,0,1);
        r(0,0,1,1,8'hC3, 0,1,1);
        r(0,0,1,0,8'hC3, 0,0,1);
        r(0,0,1,0,8'hC3, 0,0,0);
        r(0,0,1,0,8'hC3, 1,1,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,0,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,0,0,0,8'h00, 1,0,0);
        // Reset after the 3rd bit of FF, then 81 sent in full (TRAIN ignored in SHIFT).
        r(0,0,1,0,8'hFF, 1,1,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,0,0,0,8'h00, 0,1,1);
        r(0,1,0,0,8'h00, 0,0,0);
        r(0,0,0,0,8'h00, 1,0,0);
        r(0,0,1,0,8'h81, 1,1,1);
        r(0,0,0,1,8'h00, 0,0,1);
        r(0,0,0,1,8'h00, 0,0,1);
        r(0,0,0,1,8'h00, 0,0,1);
        r(0,0,0,1,8'h00, 0,0,1);
        r(0,0,0,1,8'h00, 0,0,1);
        r(0,0,0,1,8'h00, 0,0,1);
        r(0,0,0,1,8'h00, 0,1,1);
        r(0,0,0,1,8'h00, 1,0,0);
        r(0,0,0,0,8'h00, 1,0,0);
        // LSB-first instance, idle level 1: reset, then 01 gives 1 followed by seven 0s.
        r(1,1,1,1,8'h01, 0,1,0);
        r(1,1,1,1,8'h01, 0,1,0);
        r(1,0,0,0,8'h00, 1,1,0);
        r(1,0,1,0,8'h01, 1,1,1);
        r(1,0,0,0,8'hFE, 0,0,1);
        r(1,0,0,0,8'hFE, 0,0,1);
        r(1,0,0,0,8'hFE, 0,0,1);
        r(1,0,0,0,8'hFE, 0,0,1);
        r(1,0,0,0,8'hFE, 0,0,1);
        r(1,0,0,0,8'hFE, 0,0,1);
        r(1,0,0,0,8'hFE, 0,0,1);
        r(1,0,0,0,8'h00, 1,1,0);
        // One-cycle training request still completes the 1,0 pair before idling.
        r(1,0,0,1,8'h00, 0,1,1);
        r(1,0,0,0,8'h00, 0,0,1);
        r(1,0,0,0,8'h00, 0,1,0);
        r(1,0,0,0,8'h00, 1,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(i, tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
